controle_tentativas: RTL

- Sequencer for the DigiLock verify/program datapath.
- Drives the 2-bit memory index, the memory write/enable strobes and the per-digit compare request, and consumes the 1-bit digit-equality result from the 16-bit comparator.
- Counts failed attempts, holds the lock open for a fixed time, and enforces a lockout after too many failures.
- Sits between the key encoder (tecla_acionada) and the memory/comparator pair; it owns fechadura.

---
 rtl/controle_tentativas.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/controle_tentativas.sv
// controle_tentativas: DigiLock verify/program sequencer, failed-attempt counter, open hold and lockout (entry timeout under DIGILOCK_TIMEOUT_EN).
// Latency: memory/compare strobes in the same cycle as the key; fechadura rises 2 cycles after the 4th correct key.
// Backpressure: none; keys arriving in CHECK or LOCKOUT, or modo=1 keys in IDLE, are dropped with no side effects.
module controle_tentativas #(
    parameter int MAX_TENT   = 3,
    parameter int T_ABERTO   = 16,
    parameter int T_BLOQUEIO = 64,
    parameter int T_INATIVO  = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       modo,
    input  logic       tecla_acionada,
    input  logic       comparador,
    output logic [1:0] idx_mem,
    output logic       write_mem,
    output logic       enable_mem,
    output logic       comp,
    output logic       fechadura,
    output logic       bloqueado,
    output logic [1:0] tentativas,
    output logic [2:0] estado
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        CHECK   = 3'd2,
        OPEN    = 3'd3,
        LOCKOUT = 3'd4
    } state_t;

    localparam logic [7:0] ABERTO_INI   = 8'(T_ABERTO - 1);
    localparam logic [7:0] BLOQUEIO_INI = 8'(T_BLOQUEIO - 1);
    localparam logic [1:0] MAX_T        = 2'(MAX_TENT);
`ifdef DIGILOCK_TIMEOUT_EN
    localparam logic [7:0] INATIVO_INI  = 8'(T_INATIVO - 1);
`endif

    generate
        if (MAX_TENT < 1 || MAX_TENT > 3) begin : g_bad_max
            $error("MAX_TENT out of range 1..3");
        end
        if (T_ABERTO < 1 || T_ABERTO > 255) begin : g_bad_aberto
            $error("T_ABERTO out of range 1..255");
        end
        if (T_BLOQUEIO < 1 || T_BLOQUEIO > 255) begin : g_bad_bloqueio
            $error("T_BLOQUEIO out of range 1..255");
        end
        if (T_INATIVO < 1 || T_INATIVO > 255) begin : g_bad_inativo
            $error("T_INATIVO out of range 1..255");
        end
    endgenerate

    state_t     state, state_n;
    logic [1:0] idx, idx_d;
    logic       erro, erro_d;
    logic       modo_lat, modo_lat_d;
    logic [7:0] timer, timer_d;
    logic [1:0] tent, tent_d;
    logic       erro_cmp;
    logic       falha;
    logic [2:0] tent_inc;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= 2'd0;
            erro     <= 1'b0;
            modo_lat <= 1'b0;
            timer    <= 8'd0;
            tent     <= 2'd0;
        end else begin
            state    <= state_n;
            idx      <= idx_d;
            erro     <= erro_d;
            modo_lat <= modo_lat_d;
            timer    <= timer_d;
            tent     <= tent_d;
        end
    end

    always_comb begin
        state_n    = state;
        idx_d      = idx;
        erro_d     = erro;
        modo_lat_d = modo_lat;
        timer_d    = timer;
        tent_d     = tent;
        comp       = 1'b0;
        write_mem  = 1'b0;
        enable_mem = 1'b0;
        falha      = 1'b0;
        erro_cmp   = erro | ~comparador;
        tent_inc   = {1'b0, tent} + 3'd1;

        case (state)
            IDLE: begin
                if (tecla_acionada && !modo) begin
                    comp       = 1'b1;
                    enable_mem = 1'b1;
                    modo_lat_d = 1'b0;
                    state_n    = CHECK;
`ifdef DIGILOCK_TIMEOUT_EN
                    timer_d    = INATIVO_INI;
`endif
                end
            end

            ENTRY: begin
                if (tecla_acionada) begin
`ifdef DIGILOCK_TIMEOUT_EN
                    timer_d = INATIVO_INI;
`endif
                    if (modo_lat) begin
                        write_mem = 1'b1;
                        if (idx == 2'd3) begin
                            idx_d   = 2'd0;
                            state_n = IDLE;
                        end else begin
                            idx_d = idx + 2'd1;
                        end
                    end else begin
                        comp       = 1'b1;
                        enable_mem = 1'b1;
                        state_n    = CHECK;
                    end
                end
`ifdef DIGILOCK_TIMEOUT_EN
                // Abandoned entry: verify aborts count as a failure, program aborts do not.
                else if (timer == 8'd0) begin
                    idx_d   = 2'd0;
                    erro_d  = 1'b0;
                    state_n = IDLE;
                    falha   = ~modo_lat;
                end else begin
                    timer_d = timer - 8'd1;
                end
`endif
            end

            CHECK: begin
`ifdef DIGILOCK_TIMEOUT_EN
                timer_d = timer - 8'd1;
`endif
                if (idx != 2'd3) begin
                    erro_d  = erro_cmp;
                    idx_d   = idx + 2'd1;
                    state_n = ENTRY;
                end else begin
                    idx_d  = 2'd0;
                    erro_d = 1'b0;
                    if (!erro_cmp) begin
                        tent_d  = 2'd0;
                        timer_d = ABERTO_INI;
                        state_n = OPEN;
                    end else begin
                        falha = 1'b1;
                    end
                end
            end

            OPEN: begin
                if (tecla_acionada && modo) begin
                    write_mem  = 1'b1;
                    idx_d      = 2'd1;
                    modo_lat_d = 1'b1;
                    state_n    = ENTRY;
`ifdef DIGILOCK_TIMEOUT_EN
                    timer_d    = INATIVO_INI;
`endif
                end else if (timer == 8'd0) begin
                    state_n = IDLE;
                end else begin
                    timer_d = timer - 8'd1;
                end
            end

            LOCKOUT: begin
                if (timer == 8'd0) begin
                    tent_d  = 2'd0;
                    state_n = IDLE;
                end else begin
                    timer_d = timer - 8'd1;
                end
            end

            default: state_n = IDLE;
        endcase

        // Shared failed-attempt bookkeeping; the count saturates at MAX_TENT.
        if (falha) begin
            if (tent_inc >= {1'b0, MAX_T}) begin
                tent_d  = MAX_T;
                timer_d = BLOQUEIO_INI;
                state_n = LOCKOUT;
            end else begin
                tent_d  = tent_inc[1:0];
                state_n = IDLE;
            end
        end
    end

    assign idx_mem    = idx;
    assign tentativas = tent;
    assign estado     = state;
    assign fechadura  = (state == OPEN);
    assign bloqueado  = (state == LOCKOUT);

endmodule
